// File: rtl/axi_lite_sram_slave.sv
// AXI-lite slave fronting a word-addressed on-chip SRAM model with programmable latency.
// Latency: response valid LATENCY cycles after the address handshake (read) or after both aw and w are held (write).
// Backpressure: one outstanding read and one outstanding write; responses held until accepted, readies low meanwhile.
module axi_lite_sram_slave #(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ar_valid,
  output logic                    ar_ready,
  input  logic [BUS_WIDTH-1:0]    ar_addr,
  input  logic [2:0]              ar_prot,
  input  logic                    aw_valid,
  output logic                    aw_ready,
  input  logic [BUS_WIDTH-1:0]    aw_addr,
  input  logic [2:0]              aw_prot,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    wd_valid,
  output logic                    wd_ready,
  input  logic [DATA_WIDTH-1:0]   wd_data,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [1:0]              wr_breap
);

  localparam int IW = $clog2(DEPTH);
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0]      CNT_INIT   = CW'(LATENCY - 1);
  localparam logic [BUS_WIDTH:0] ADDR_LIMIT = (BUS_WIDTH + 1)'(DEPTH * 4);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_t;

  // Byte address is in range when it falls inside the DEPTH-word array
  function automatic logic in_range(input logic [BUS_WIDTH-1:0] a);
    return ({1'b0, a} < ADDR_LIMIT);
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [BUS_WIDTH-1:0] a);
    return a[IW+1:2];
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Protection bits carry no meaning for this memory
  logic unused_prot;
  assign unused_prot = ^{ar_prot, aw_prot};

  // ---------------------------------------------------------------- read path
  rstate_t               rstate, rstate_nxt;
  logic [CW-1:0]         rcnt;
  logic [BUS_WIDTH-1:0]  raddr;
  logic                  ar_hs, rd_hs, rcapture;

  assign ar_ready = (rstate == R_IDLE);
  assign rd_valid = (rstate == R_RESP);
  assign ar_hs    = ar_valid & ar_ready;
  assign rd_hs    = rd_valid & rd_ready;
  assign rcapture = (rstate == R_WAIT) && (rcnt == '0);

  // Read FSM next-state
  always_comb begin
    rstate_nxt = rstate;
    case (rstate)
      R_IDLE:  if (ar_hs)       rstate_nxt = R_WAIT;
      R_WAIT:  if (rcnt == '0)  rstate_nxt = R_RESP;
      R_RESP:  if (rd_hs)       rstate_nxt = R_IDLE;
      default:                  rstate_nxt = R_IDLE;
    endcase
  end

  // Read FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rstate <= R_IDLE;
    else        rstate <= rstate_nxt;
  end

  // Read address latch, latency countdown and response data capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rcnt    <= '0;
      raddr   <= '0;
      rd_data <= '0;
    end else begin
      if (ar_hs) begin
        rcnt  <= CNT_INIT;
        raddr <= ar_addr;
      end else if ((rstate == R_WAIT) && (rcnt != '0)) begin
        rcnt <= rcnt - 1'b1;
      end
      // Sampling mem here sees the pre-commit word if a write commits on the same edge
      if (rcapture)
        rd_data <= in_range(raddr) ? mem[word_idx(raddr)] : '0;
    end
  end

  // --------------------------------------------------------------- write path
  wstate_t               wstate, wstate_nxt;
  logic [CW-1:0]         wcnt;
  logic [BUS_WIDTH-1:0]  waddr;
  logic [DATA_WIDTH-1:0] wdat;
  logic [SW-1:0]         wstrb_q;
  logic                  aw_got, w_got;
  logic                  aw_hs, w_hs, wr_hs, have_both, wcommit;

  assign aw_ready  = (wstate == W_IDLE) & ~aw_got;
  assign wd_ready  = (wstate == W_IDLE) & ~w_got;
  assign wr_valid  = (wstate == W_RESP);
  assign aw_hs     = aw_valid & aw_ready;
  assign w_hs      = wd_valid & wd_ready;
  assign wr_hs     = wr_valid & wr_ready;
  // Counts the handshake happening this cycle so the second half can launch the wait immediately
  assign have_both = (aw_got | aw_hs) & (w_got | w_hs);
  assign wcommit   = (wstate == W_WAIT) && (wcnt == '0);

  // Write FSM next-state
  always_comb begin
    wstate_nxt = wstate;
    case (wstate)
      W_IDLE:  if (have_both)   wstate_nxt = W_WAIT;
      W_WAIT:  if (wcnt == '0)  wstate_nxt = W_RESP;
      W_RESP:  if (wr_hs)       wstate_nxt = W_IDLE;
      default:                  wstate_nxt = W_IDLE;
    endcase
  end

  // Write FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wstate <= W_IDLE;
    else        wstate <= wstate_nxt;
  end

  // Independent aw/w capture, latency countdown and response code
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      waddr    <= '0;
      wdat     <= '0;
      wstrb_q  <= '0;
      wcnt     <= '0;
      wr_breap <= 2'b00;
    end else begin
      if (aw_hs) begin
        aw_got <= 1'b1;
        waddr  <= aw_addr;
      end
      if (w_hs) begin
        w_got   <= 1'b1;
        wdat    <= wd_data;
        wstrb_q <= wstrb;
      end
      if ((wstate == W_IDLE) && have_both)
        wcnt <= CNT_INIT;
      else if ((wstate == W_WAIT) && (wcnt != '0))
        wcnt <= wcnt - 1'b1;
      if (wcommit)
        wr_breap <= in_range(waddr) ? 2'b00 : 2'b10;
      if (wr_hs) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
    end
  end

  // Byte-masked commit; the array itself is never reset
  always_ff @(posedge clk) begin
    if (wcommit && in_range(waddr)) begin
      for (int i = 0; i < SW; i++) begin
        if (wstrb_q[i])
          mem[word_idx(waddr)][i*8 +: 8] <= wdat[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Directed bench for axi_lite_sram_slave: vector table of single transactions plus
// hand sequences for split aw/w, read backpressure and reset during a pending write.
module tb_axi_lite_sram_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        ar_valid, ar_ready, aw_valid, aw_ready;
  logic [31:0] ar_addr, aw_addr;
  logic [2:0]  ar_prot, aw_prot;
  logic        rd_valid, rd_ready, wd_valid, wd_ready, wr_valid, wr_ready;
  logic [31:0] rd_data, wd_data;
  logic [3:0]  wstrb;
  logic [1:0]  wr_breap;

  int n_total = 0;
  int n_pass  = 0;

  axi_lite_sram_slave #(
    .BUS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(1024), .LATENCY(2)
  ) dut (
    .clk(clk), .reset(reset),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_prot(ar_prot),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_prot(aw_prot),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wstrb(wstrb),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_breap(wr_breap)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;   // read data for reads, response code for writes
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Entered and left at 1 time unit after a rising edge
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output int lat);
    aw_valid = 1'b1; aw_addr = a; wd_valid = 1'b1; wd_data = d; wstrb = s;
    @(posedge clk); #1;
    aw_valid = 1'b0; wd_valid = 1'b0;
    lat = 0;
    while (!wr_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    resp = wr_breap;
    wr_ready = 1'b1;
    @(posedge clk); #1;
    wr_ready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output int lat);
    ar_valid = 1'b1; ar_addr = a;
    @(posedge clk); #1;
    ar_valid = 1'b0;
    lat = 0;
    while (!rd_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    d = rd_data;
    rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] d, d0;
    int          lat;
    logic        ok;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 32'h0000_0013, 32'h0,         4'h0, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 32'h0000_0014, 32'h1122_3344, 4'hF, 32'h0};
    vecs[4]  = '{1'b1, 32'h0000_0014, 32'hAABB_CCDD, 4'h5, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 32'h11BB_33DD};
    vecs[6]  = '{1'b1, 32'h0000_0FFC, 32'h0BAD_F00D, 4'hF, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h0BAD_F00D};
    vecs[8]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h0};
    vecs[9]  = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 32'h2};
    vecs[10] = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'h0};
    vecs[11] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hCAFE_F00D};
    vecs[12] = '{1'b1, 32'h0000_0020, 32'h5555_5555, 4'hF, 32'h0};
    vecs[13] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h5555_5555};

    reset = 1'b0;
    ar_valid = 0; aw_valid = 0; wd_valid = 0; rd_ready = 0; wr_ready = 0;
    ar_addr = 0; aw_addr = 0; wd_data = 0; wstrb = 0; ar_prot = 0; aw_prot = 0;

    // Values while reset is held
    #2;
    check("rst ar_ready", {31'b0, ar_ready}, 32'd1);
    check("rst aw_ready", {31'b0, aw_ready}, 32'd1);
    check("rst wd_ready", {31'b0, wd_ready}, 32'd1);
    check("rst rd_valid", {31'b0, rd_valid}, 32'd0);
    check("rst wr_valid", {31'b0, wr_valid}, 32'd0);
    check("rst rd_data",  rd_data, 32'd0);
    check("rst wr_breap", {30'b0, wr_breap}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("post-rst readies", {29'b0, ar_ready, aw_ready, wd_ready}, 32'h7);

    // Vector table
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, lat);
        check($sformatf("vec%0d wr resp", i), {30'b0, resp}, vecs[i].exp);
        check($sformatf("vec%0d wr latency", i), lat, 32'd2);
        check($sformatf("vec%0d wr_valid drop", i), {31'b0, wr_valid}, 32'd0);
      end else begin
        do_read(vecs[i].addr, d, lat);
        check($sformatf("vec%0d rd data", i), d, vecs[i].exp);
        check($sformatf("vec%0d rd latency", i), lat, 32'd2);
        check($sformatf("vec%0d rd_valid drop", i), {31'b0, rd_valid}, 32'd0);
      end
    end

    // w first, aw three cycles later, byte 0 only
    wd_valid = 1'b1; wd_data = 32'h0000_00AA; wstrb = 4'b0001;
    @(posedge clk); #1;
    wd_valid = 1'b0;
    check("split wd_ready low", {31'b0, wd_ready}, 32'd0);
    check("split aw_ready high", {31'b0, aw_ready}, 32'd1);
    repeat (2) begin @(posedge clk); #1; end
    check("split no resp w/o aw", {31'b0, wr_valid}, 32'd0);
    aw_valid = 1'b1; aw_addr = 32'h10;
    @(posedge clk); #1;
    aw_valid = 1'b0;
    lat = 0;
    while (!wr_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("split wr latency", lat, 32'd2);
    check("split wr resp", {30'b0, wr_breap}, 32'd0);
    wr_ready = 1'b1; @(posedge clk); #1; wr_ready = 1'b0;
    do_read(32'h10, d, lat);
    check("split readback", d, 32'hDEAD_BEAA);

    // Read response held under backpressure
    ar_valid = 1'b1; ar_addr = 32'h10;
    @(posedge clk); #1;
    ar_valid = 1'b0;
    lat = 0;
    while (!rd_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("bp rd latency", lat, 32'd2);
    d0 = rd_data;
    check("bp rd data", d0, 32'hDEAD_BEAA);
    ok = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      ok &= rd_valid && (rd_data == d0) && !ar_ready;
    end
    check("bp hold stable", {31'b0, ok}, 32'd1);
    rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    check("bp rd_valid drop", {31'b0, rd_valid}, 32'd0);
    check("bp ar_ready back", {31'b0, ar_ready}, 32'd1);

    // Reset while the write to 0x20 is still waiting to commit
    aw_valid = 1'b1; aw_addr = 32'h20; wd_valid = 1'b1; wd_data = 32'h9999_9999; wstrb = 4'hF;
    @(posedge clk); #1;
    aw_valid = 1'b0; wd_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #2;
    check("midrst wr_valid", {31'b0, wr_valid}, 32'd0);
    check("midrst readies", {29'b0, ar_ready, aw_ready, wd_ready}, 32'h7);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    do_read(32'h20, d, lat);
    check("midrst old data", d, 32'h5555_5555);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
